// File: rtl/stall_ctrl_de.sv
// D-stage hazard/stall controller: Tuse/Tnew register hazards plus
// mult/div busy tracking so HI/LO users wait in D.
module stall_ctrl_de #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs_addr,
  input  logic [4:0] D_rt_addr,
  input  logic [1:0] D_rs_tuse,
  input  logic [1:0] D_rt_tuse,
  input  logic       D_md_use,
  input  logic [4:0] E_wa,
  input  logic [1:0] E_tnew,
  input  logic [4:0] M_wa,
  input  logic [1:0] M_tnew,
  input  logic       E_md_start,
  input  logic       E_md_is_div,
  input  logic       int_req,
  output logic       stopen_PC,
  output logic       stopen_FD,
  output logic       clear_DE,
  output logic       md_busy,
  output logic [3:0] md_cnt
);

  if (MULT_CYC < 1 || MULT_CYC > 15 || DIV_CYC < 1 || DIV_CYC > 15) begin : g_chk
    $error("stall_ctrl_de: MULT_CYC/DIV_CYC must be in 1..15");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;

  logic w_rs_stall;
  logic w_rt_stall;
  logic w_md_stall;
  logic w_stall;

  // Equal Tnew/Tuse is covered by forwarding, hence strict '>'
  assign w_rs_stall = (D_rs_addr != 5'd0) && (D_rs_tuse != 2'd3) &&
                      ((D_rs_addr == E_wa && E_tnew > D_rs_tuse) ||
                       (D_rs_addr == M_wa && M_tnew > D_rs_tuse));

  assign w_rt_stall = (D_rt_addr != 5'd0) && (D_rt_tuse != 2'd3) &&
                      ((D_rt_addr == E_wa && E_tnew > D_rt_tuse) ||
                       (D_rt_addr == M_wa && M_tnew > D_rt_tuse));

  assign w_md_stall = D_md_use && (md_busy || E_md_start);

  assign w_stall = (w_rs_stall || w_rt_stall || w_md_stall) &&
                   !int_req && !reset;

  assign stopen_PC = w_stall;
  assign stopen_FD = w_stall;
  assign clear_DE  = w_stall;

  assign md_busy = (r_state == BUSY);
  assign md_cnt  = r_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = 4'd0;
        if (E_md_start && !int_req) begin
          w_state_nxt = BUSY;
          w_cnt_nxt   = E_md_is_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
        end
      end
      BUSY: begin
        // Starts while busy are ignored; the count always runs out
        if (r_cnt <= 4'd1) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_stall_ctrl_de.sv
// Directed bench for stall_ctrl_de: hazards, mult/div busy,
// reset and interrupt priority.
module tb_stall_ctrl_de;

  logic       clk;
  logic       reset;
  logic [4:0] D_rs_addr;
  logic [4:0] D_rt_addr;
  logic [1:0] D_rs_tuse;
  logic [1:0] D_rt_tuse;
  logic       D_md_use;
  logic [4:0] E_wa;
  logic [1:0] E_tnew;
  logic [4:0] M_wa;
  logic [1:0] M_tnew;
  logic       E_md_start;
  logic       E_md_is_div;
  logic       int_req;
  logic       stopen_PC;
  logic       stopen_FD;
  logic       clear_DE;
  logic       md_busy;
  logic [3:0] md_cnt;

  int n_run;
  int n_fail;

  stall_ctrl_de #(.MULT_CYC(5), .DIV_CYC(10)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs_addr  (D_rs_addr),
    .D_rt_addr  (D_rt_addr),
    .D_rs_tuse  (D_rs_tuse),
    .D_rt_tuse  (D_rt_tuse),
    .D_md_use   (D_md_use),
    .E_wa       (E_wa),
    .E_tnew     (E_tnew),
    .M_wa       (M_wa),
    .M_tnew     (M_tnew),
    .E_md_start (E_md_start),
    .E_md_is_div(E_md_is_div),
    .int_req    (int_req),
    .stopen_PC  (stopen_PC),
    .stopen_FD  (stopen_FD),
    .clear_DE   (clear_DE),
    .md_busy    (md_busy),
    .md_cnt     (md_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    check({tag, ".pc"}, 32'(stopen_PC), 32'(exp));
    check({tag, ".fd"}, 32'(stopen_FD), 32'(exp));
    check({tag, ".de"}, 32'(clear_DE), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    D_rs_addr   = 5'd0;
    D_rt_addr   = 5'd0;
    D_rs_tuse   = 2'd3;
    D_rt_tuse   = 2'd3;
    D_md_use    = 1'b0;
    E_wa        = 5'd0;
    E_tnew      = 2'd0;
    M_wa        = 5'd0;
    M_tnew      = 2'd0;
    E_md_start  = 1'b0;
    E_md_is_div = 1'b0;
    int_req     = 1'b0;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    clr();
    reset = 1'b1;
    tick();
    tick();
    // hazard present while in reset: outputs must stay 0
    E_wa = 5'd5; E_tnew = 2'd2; D_rs_addr = 5'd5; D_rs_tuse = 2'd0;
    #1;
    chk_stall("rst_hz", 1'b0);
    check("rst_busy", 32'(md_busy), 32'd0);
    check("rst_cnt", 32'(md_cnt), 32'd0);
    tick();
    reset = 1'b0;
    clr();

    // 1. load-use
    E_wa = 5'd5; E_tnew = 2'd2; D_rs_addr = 5'd5; D_rs_tuse = 2'd0;
    #1;
    chk_stall("lu0", 1'b1);
    tick();
    E_wa = 5'd0; M_wa = 5'd5; M_tnew = 2'd1;
    #1;
    chk_stall("lu1", 1'b1);
    tick();
    M_tnew = 2'd0;
    #1;
    chk_stall("lu2", 1'b0);

    // 2. no-stall and rt cases
    clr();
    M_wa = 5'd8; M_tnew = 2'd1; D_rt_addr = 5'd8; D_rt_tuse = 2'd1;
    #1;
    chk_stall("rt_eq", 1'b0);
    D_rt_tuse = 2'd0;
    #1;
    chk_stall("rt_m", 1'b1);
    clr();
    E_wa = 5'd0; D_rs_addr = 5'd0; E_tnew = 2'd2; D_rs_tuse = 2'd0;
    #1;
    chk_stall("r0", 1'b0);
    E_wa = 5'd7; D_rs_addr = 5'd7; D_rs_tuse = 2'd3;
    #1;
    chk_stall("nouse", 1'b0);
    D_rs_tuse = 2'd1; E_tnew = 2'd1;
    #1;
    chk_stall("e_eq", 1'b0);
    E_tnew = 2'd2;
    #1;
    chk_stall("e_gt", 1'b1);
    D_rs_addr = 5'd6;
    #1;
    chk_stall("addr_ne", 1'b0);

    // 3. mult with HI/LO user held in D
    clr();
    tick();
    D_md_use = 1'b1; E_md_start = 1'b1; E_md_is_div = 1'b0;
    #1;
    chk_stall("mul_t", 1'b1);
    tick();
    E_md_start = 1'b0;
    for (int k = 5; k >= 1; k--) begin
      #1;
      check($sformatf("mul_cnt%0d", k), 32'(md_cnt), 32'(k));
      check($sformatf("mul_bsy%0d", k), 32'(md_busy), 32'd1);
      chk_stall($sformatf("mul_st%0d", k), 1'b1);
      tick();
    end
    #1;
    check("mul_end_cnt", 32'(md_cnt), 32'd0);
    check("mul_end_bsy", 32'(md_busy), 32'd0);
    chk_stall("mul_end", 1'b0);

    // 4. div interrupted by reset
    clr();
    E_md_start = 1'b1; E_md_is_div = 1'b1;
    tick();
    E_md_start = 1'b0;
    check("div_c1", 32'(md_cnt), 32'd10);
    tick();
    check("div_c2", 32'(md_cnt), 32'd9);
    tick();
    check("div_c3", 32'(md_cnt), 32'd8);
    reset = 1'b1; D_md_use = 1'b1;
    #1;
    chk_stall("div_rst", 1'b0);
    tick();
    check("div_rb", 32'(md_busy), 32'd0);
    check("div_rc", 32'(md_cnt), 32'd0);
    reset = 1'b0;
    #1;
    chk_stall("div_post", 1'b0);

    // 5. interrupt priority
    clr();
    int_req = 1'b1; E_md_start = 1'b1; D_md_use = 1'b1;
    #1;
    chk_stall("irq_md", 1'b0);
    tick();
    clr();
    #1;
    check("irq_idle", 32'(md_busy), 32'd0);
    check("irq_cnt", 32'(md_cnt), 32'd0);
    E_wa = 5'd5; E_tnew = 2'd2; D_rs_addr = 5'd5; D_rs_tuse = 2'd0;
    int_req = 1'b1;
    #1;
    chk_stall("irq_lu", 1'b0);

    // 6. second start while busy, plus int_req mid-count
    clr();
    E_md_start = 1'b1;
    tick();
    E_md_start = 1'b0;
    check("ov_c5", 32'(md_cnt), 32'd5);
    tick();
    E_md_start = 1'b1; E_md_is_div = 1'b1;
    check("ov_c4", 32'(md_cnt), 32'd4);
    tick();
    clr();
    int_req = 1'b1;
    check("ov_c3", 32'(md_cnt), 32'd3);
    tick();
    int_req = 1'b0;
    check("ov_c2", 32'(md_cnt), 32'd2);
    tick();
    check("ov_c1", 32'(md_cnt), 32'd1);
    check("ov_b1", 32'(md_busy), 32'd1);
    tick();
    check("ov_c0", 32'(md_cnt), 32'd0);
    check("ov_b0", 32'(md_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
